imem_loader: RTL and testbench

- Write-side companion to the instruction memory: a boot-time loader that receives a byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words.
- Drives the memory's write port with sequential word addresses.
- Verifies a trailing checksum and reports done/error.
- Sits between the host byte source (UART RX or testbench) and the imem write port. The core is held via o_busy until loading completes.

---
 rtl/imem_pkg.sv | 26 ++
 rtl/byte_packer.sv | 36 +++
 rtl/imem_loader.sv | 129 ++++++++++++
 tb/tb_imem_loader.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory boot loader.
package imem_pkg;

  localparam int IMEM_DEPTH = 4096;
  localparam int IMEM_AW    = 12;

  // Framing around the payload: two length bytes in front, one checksum byte behind.
  localparam int HDR_BYTES  = 2;
  localparam int CSUM_BYTES = 1;

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA,
    CHECK,
    DONE,
    ERROR
  } loader_state_e;

  // Total number of stream bytes a session of n words occupies.
  function automatic int stream_bytes(input int n);
    return HDR_BYTES + 4 * n + CSUM_BYTES;
  endfunction

endpackage

// File: rtl/byte_packer.sv
// Little-endian 4-byte to 32-bit word assembler with a one-cycle word_valid pulse.
module byte_packer (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_clear,
  input  logic        i_accept,
  input  logic [7:0]  i_byte,
  output logic [1:0]  o_byte_idx,
  output logic        o_word_valid,
  output logic [31:0] o_word
);

  logic [3:0][7:0] lanes;
  logic [1:0]      byte_idx;
  logic            word_valid;

  // Drop each accepted byte into its lane and pulse word_valid the cycle after the 4th.
  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) begin
      lanes      <= '0;
      byte_idx   <= 2'd0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= i_accept && (byte_idx == 2'd3);
      if (i_accept) begin
        lanes[byte_idx] <= i_byte;
        byte_idx        <= byte_idx + 2'd1;
      end
    end
  end

  assign o_byte_idx   = byte_idx;
  assign o_word_valid = word_valid;
  assign o_word       = lanes;

endmodule

// File: rtl/imem_loader.sv
// Boot-time loader: byte stream in, sequential 32-bit imem writes out, trailing checksum check.
module imem_loader
  import imem_pkg::*;
#(
  parameter int DEPTH = IMEM_DEPTH,
  parameter int AW    = IMEM_AW
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_start,
  input  logic          i_valid,
  input  logic [7:0]    i_byte,
  output logic          o_ready,
  output logic          o_wr_en,
  output logic [AW-1:0] o_wr_addr,
  output logic [31:0]   o_wr_data,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_error,
  output logic [15:0]   o_words
);

  localparam logic [16:0] DEPTH_W = 17'(DEPTH);

  loader_state_e state;
  loader_state_e state_nxt;

  logic [15:0]   len;
  logic [15:0]   len_full;
  logic [15:0]   words;
  logic [AW-1:0] addr;
  logic [7:0]    checksum;
  logic          accept;
  logic          start_ok;
  logic [1:0]    byte_idx;
  logic          word_valid;
  logic [31:0]   word;

  assign accept   = i_valid && o_ready;
  assign start_ok = i_start && ((state == IDLE) || (state == DONE) || (state == ERROR));
  assign len_full = {i_byte, len[7:0]};

  byte_packer u_packer (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_clear      (start_ok),
    .i_accept     (accept && (state == DATA)),
    .i_byte       (i_byte),
    .o_byte_idx   (byte_idx),
    .o_word_valid (word_valid),
    .o_word       (word)
  );

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic; the last data byte moves straight to CHECK so its write overlaps the checksum phase.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE, ERROR: if (i_start) state_nxt = LEN_LO;
      LEN_LO:            if (accept) state_nxt = LEN_HI;
      LEN_HI: begin
        if (accept) begin
          if ({1'b0, len_full} > DEPTH_W) state_nxt = ERROR;
          else if (len_full == 16'd0)     state_nxt = CHECK;
          else                            state_nxt = DATA;
        end
      end
      DATA: begin
        if (accept && (byte_idx == 2'd3) && (words == len - 16'd1)) state_nxt = CHECK;
      end
      CHECK: begin
        if (accept) state_nxt = (i_byte == checksum) ? DONE : ERROR;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Status outputs decoded from the current state.
  always_comb begin
    o_ready = 1'b0;
    o_busy  = 1'b0;
    o_done  = 1'b0;
    o_error = 1'b0;
    case (state)
      LEN_LO, LEN_HI, DATA, CHECK: begin
        o_ready = 1'b1;
        o_busy  = 1'b1;
      end
      DONE:    o_done  = 1'b1;
      ERROR:   o_error = 1'b1;
      default: ;
    endcase
  end

  // Length capture, running checksum, and write address / word count advancing on each write.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      len      <= '0;
      words    <= '0;
      addr     <= '0;
      checksum <= '0;
    end else begin
      if (start_ok) begin
        len      <= '0;
        words    <= '0;
        addr     <= '0;
        checksum <= '0;
      end
      if (accept && (state == LEN_LO)) len[7:0]  <= i_byte;
      if (accept && (state == LEN_HI)) len[15:8] <= i_byte;
      if (accept && (state == DATA))   checksum  <= checksum + i_byte;
      if (word_valid) begin
        addr  <= addr + 1'b1;
        words <= words + 16'd1;
      end
    end
  end

  assign o_wr_en   = word_valid;
  assign o_wr_addr = addr;
  assign o_wr_data = word;
  assign o_words   = words;

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader.
module tb_imem_loader;
  import imem_pkg::*;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_start = 1'b0;
  logic        i_valid = 1'b0;
  logic [7:0]  i_byte = 8'h00;
  logic        o_ready;
  logic        o_wr_en;
  logic [11:0] o_wr_addr;
  logic [31:0] o_wr_data;
  logic        o_busy;
  logic        o_done;
  logic        o_error;
  logic [15:0] o_words;

  int tests_run = 0;
  int failures  = 0;
  int wr_seen   = 0;

  imem_loader #(.DEPTH(IMEM_DEPTH), .AW(IMEM_AW)) dut (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_start   (i_start),
    .i_valid   (i_valid),
    .i_byte    (i_byte),
    .o_ready   (o_ready),
    .o_wr_en   (o_wr_en),
    .o_wr_addr (o_wr_addr),
    .o_wr_data (o_wr_data),
    .o_busy    (o_busy),
    .o_done    (o_done),
    .o_error   (o_error),
    .o_words   (o_words)
  );

  // Free-running 100 MHz clock.
  always #5 i_clk = ~i_clk;

  // Count every write strobe, sampled mid-cycle.
  always @(negedge i_clk) begin
    if (o_wr_en) wr_seen++;
  end

  // Hard time limit so a stuck handshake cannot hang the run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected finish");
    $fatal(1, "[TB] time limit reached");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    tests_run++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Offer one byte and hold it until the loader takes it; returns #1 after the accepting edge.
  task automatic applyStimulus(input logic [7:0] b);
    int wait_cycles;
    wait_cycles = 0;
    @(negedge i_clk);
    i_valid = 1'b1;
    i_byte  = b;
    while (!o_ready && wait_cycles < 20) begin
      @(negedge i_clk);
      wait_cycles++;
    end
    if (wait_cycles >= 20) checkOutput("ready_timeout", 64'(o_ready), 64'd1);
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
  endtask

  task automatic pulseStart();
    @(negedge i_clk);
    i_start = 1'b1;
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  // One session of up to two words; each write is checked in the cycle right after its 4th byte.
  task automatic sendFrame(input string tag, input logic [15:0] n, input logic [31:0] w0,
                           input logic [31:0] w1, input logic [7:0] csum, input bit gaps);
    logic [31:0] wds [2];
    logic [31:0] w;
    wds[0] = w0;
    wds[1] = w1;
    pulseStart();
    applyStimulus(n[7:0]);
    applyStimulus(n[15:8]);
    for (int i = 0; i < int'(n); i++) begin
      w = wds[i];
      for (int b = 0; b < 4; b++) begin
        if (gaps) begin
          idleCycles($urandom_range(0, 2));
          if ($urandom_range(0, 2) == 0) pulseStart();
        end
        applyStimulus(w[8*b +: 8]);
      end
      checkOutput({tag, "_wr_en"}, 64'(o_wr_en), 64'd1);
      checkOutput({tag, "_wr_addr"}, 64'(o_wr_addr), 64'(i));
      checkOutput({tag, "_wr_data"}, 64'(o_wr_data), 64'(w));
    end
    if (gaps) idleCycles($urandom_range(0, 2));
    applyStimulus(csum);
  endtask

  initial begin
    int wr_base;

    // Reset state
    idleCycles(3);
    checkOutput("rst_ready", 64'(o_ready), 64'd0);
    checkOutput("rst_busy", 64'(o_busy), 64'd0);
    checkOutput("rst_done", 64'(o_done), 64'd0);
    checkOutput("rst_error", 64'(o_error), 64'd0);
    checkOutput("rst_wr_en", 64'(o_wr_en), 64'd0);
    checkOutput("rst_words", 64'(o_words), 64'd0);
    checkOutput("rst_addr", 64'(o_wr_addr), 64'd0);
    @(negedge i_clk);
    i_reset = 1'b0;

    // N=2 good stream, back-to-back
    wr_base = wr_seen;
    sendFrame("n2_good", 16'd2, 32'h0000_0513, 32'h0000_02B3, 8'hCD, 1'b0);
    checkOutput("n2_good_done", 64'(o_done), 64'd1);
    checkOutput("n2_good_error", 64'(o_error), 64'd0);
    checkOutput("n2_good_busy", 64'(o_busy), 64'd0);
    checkOutput("n2_good_words", 64'(o_words), 64'd2);
    idleCycles(2);
    checkOutput("n2_good_nwr", 64'(wr_seen - wr_base), 64'd2);

    // N=2 with a wrong checksum
    wr_base = wr_seen;
    sendFrame("n2_bad", 16'd2, 32'h0000_0513, 32'h0000_02B3, 8'hCE, 1'b0);
    checkOutput("n2_bad_error", 64'(o_error), 64'd1);
    checkOutput("n2_bad_done", 64'(o_done), 64'd0);
    checkOutput("n2_bad_busy", 64'(o_busy), 64'd0);
    idleCycles(2);
    checkOutput("n2_bad_nwr", 64'(wr_seen - wr_base), 64'd2);

    // Length overflow N=4097, then bytes offered while not ready
    wr_base = wr_seen;
    pulseStart();
    applyStimulus(8'h01);
    checkOutput("ovf_mid_busy", 64'(o_busy), 64'd1);
    applyStimulus(8'h10);
    checkOutput("ovf_error", 64'(o_error), 64'd1);
    checkOutput("ovf_ready", 64'(o_ready), 64'd0);
    checkOutput("ovf_busy", 64'(o_busy), 64'd0);
    @(negedge i_clk);
    i_valid = 1'b1;
    i_byte  = 8'hAA;
    idleCycles(3);
    i_valid = 1'b0;
    checkOutput("ovf_ready_after", 64'(o_ready), 64'd0);
    checkOutput("ovf_error_after", 64'(o_error), 64'd1);
    checkOutput("ovf_nwr", 64'(wr_seen - wr_base), 64'd0);

    // N=0 with checksum 0x00 then 0x01
    wr_base = wr_seen;
    sendFrame("n0_good", 16'd0, 32'h0, 32'h0, 8'h00, 1'b0);
    checkOutput("n0_good_done", 64'(o_done), 64'd1);
    checkOutput("n0_good_words", 64'(o_words), 64'd0);
    sendFrame("n0_bad", 16'd0, 32'h0, 32'h0, 8'h01, 1'b0);
    checkOutput("n0_bad_error", 64'(o_error), 64'd1);
    checkOutput("n0_bad_done", 64'(o_done), 64'd0);
    idleCycles(2);
    checkOutput("n0_nwr", 64'(wr_seen - wr_base), 64'd0);

    // Reset after 6 bytes of an N=4 session
    pulseStart();
    applyStimulus(8'h04);
    applyStimulus(8'h00);
    applyStimulus(8'h11);
    applyStimulus(8'h22);
    applyStimulus(8'h33);
    applyStimulus(8'h44);
    checkOutput("midrst_wr_data", 64'(o_wr_data), 64'h4433_2211);
    @(negedge i_clk);
    i_reset = 1'b1;
    @(posedge i_clk);
    #1;
    i_reset = 1'b0;
    checkOutput("midrst_ready", 64'(o_ready), 64'd0);
    checkOutput("midrst_busy", 64'(o_busy), 64'd0);
    checkOutput("midrst_wr_en", 64'(o_wr_en), 64'd0);
    checkOutput("midrst_addr", 64'(o_wr_addr), 64'd0);
    checkOutput("midrst_data", 64'(o_wr_data), 64'd0);
    checkOutput("midrst_words", 64'(o_words), 64'd0);
    sendFrame("after_rst", 16'd1, 32'hDEAD_BEEF, 32'h0, 8'h38, 1'b0);
    checkOutput("after_rst_done", 64'(o_done), 64'd1);
    checkOutput("after_rst_words", 64'(o_words), 64'd1);

    // Gappy N=2 stream with stray start pulses, then a restart from DONE
    wr_base = wr_seen;
    sendFrame("n2_gaps", 16'd2, 32'h0000_0513, 32'h0000_02B3, 8'hCD, 1'b1);
    checkOutput("n2_gaps_done", 64'(o_done), 64'd1);
    checkOutput("n2_gaps_words", 64'(o_words), 64'd2);
    idleCycles(2);
    checkOutput("n2_gaps_nwr", 64'(wr_seen - wr_base), 64'd2);
    sendFrame("restart", 16'd1, 32'hDEAD_BEEF, 32'h0, 8'h38, 1'b0);
    checkOutput("restart_done", 64'(o_done), 64'd1);
    checkOutput("restart_words", 64'(o_words), 64'd1);
    checkOutput("restart_bytes", 64'(stream_bytes(int'(o_words))), 64'd7);

    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
